// File: rtl/seq_div_32_if.sv
// Handshake and result bus for the sequential 32-bit divider.
interface seq_div_32_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_div_32.sv
// Unsigned restoring divider: one quotient bit per clock through a single
// add_sub_32 in subtract mode. Results are held in flops until the next done.

// 32-bit adder/subtractor. mode=1 computes a-b; carry_out=1 means no borrow.
module add_sub_32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        mode,
  output logic [31:0] sum,
  output logic        carry_out
);
  logic [31:0] b_x;
  assign b_x              = b ^ {32{mode}};
  assign {carry_out, sum} = {1'b0, a} + {1'b0, b_x} + {32'b0, mode};
endmodule

module seq_div_32 #(
  parameter int WIDTH = 32  // add_sub_32 is fixed at 32 bits
) (
  input  logic         clk,
  input  logic         rst_n,
  seq_div_32_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] r_q, q_q, d_q;

  logic             busy_q, done_q, dbz_q;
  logic [WIDTH-1:0] quot_q, rem_q;

  // One iteration: shift R left pulling in Q's top bit; the bit falling out
  // of R extends the compare to WIDTH+1 bits so divisors >= 2^31 work.
  logic             msb, co, take;
  logic [WIDTH-1:0] rs, trial, r_nxt, q_nxt;
  logic             accept, dz, last;

  assign msb   = r_q[WIDTH-1];
  assign rs    = {r_q[WIDTH-2:0], q_q[WIDTH-1]};

  add_sub_32 u_sub (
    .a         (rs),
    .b         (d_q),
    .mode      (1'b1),
    .sum       (trial),
    .carry_out (co)
  );

  assign take  = msb | co;
  assign r_nxt = take ? trial : rs;
  assign q_nxt = {q_q[WIDTH-2:0], take};

  // start is only honoured outside RUN; a zero divisor short-circuits to DONE
  assign accept = (state_q != RUN) && bus.start;
  assign dz     = (bus.divisor == '0);
  assign last   = (state_q == RUN) && (cnt_q == CW'(1));

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = dz ? DONE : RUN;
      RUN:     if (cnt_q == CW'(1)) state_d = DONE;
      DONE:    if (bus.start) state_d = dz ? DONE : RUN;
               else           state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Working registers: load on accept, iterate while in RUN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q   <= '0;
      q_q   <= '0;
      d_q   <= '0;
      cnt_q <= '0;
    end else if (accept && !dz) begin
      r_q   <= '0;
      q_q   <= bus.dividend;
      d_q   <= bus.divisor;
      cnt_q <= CW'(WIDTH);
    end else if (state_q == RUN) begin
      r_q   <= r_nxt;
      q_q   <= q_nxt;
      cnt_q <= cnt_q - CW'(1);
    end
  end

  // Output flops: status follows next state, results update only entering DONE
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      quot_q <= '0;
      rem_q  <= '0;
      dbz_q  <= 1'b0;
    end else begin
      busy_q <= (state_d == RUN);
      done_q <= (state_d == DONE);
      if (accept && dz) begin
        quot_q <= '1;
        rem_q  <= bus.dividend;
        dbz_q  <= 1'b1;
      end else if (last) begin
        quot_q <= q_nxt;
        rem_q  <= r_nxt;
        dbz_q  <= 1'b0;
      end
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quotient    = quot_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;
endmodule
